vga_timing_gen: RTL

Parametrised VGA raster timing generator with a pixel-fetch read port. It replaces the fixed 640x480 generator. It counts exact H/V totals with per-phase porch and sync parameters and configurable sync polarity. It issues sequential framebuffer read addresses for active pixels and delays sync/blank through a pipeline matched to the memory read latency, so that the colour outputs line up with HS/VS.

---
 rtl/vga_timing_gen.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with a latency-matched framebuffer read port.
// Define VGA_TEST_PATTERN_EN to add the pattern_en input and an internal colour-bar source.
module vga_timing_gen #(
    parameter int H_ACTIVE       = 640,
    parameter int H_FRONT        = 16,
    parameter int H_SYNC         = 96,
    parameter int H_BACK         = 48,
    parameter int V_ACTIVE       = 480,
    parameter int V_FRONT        = 10,
    parameter int V_SYNC         = 2,
    parameter int V_BACK         = 33,
    parameter int HS_ACTIVE_HIGH = 0,
    parameter int VS_ACTIVE_HIGH = 0,
    parameter int READ_LATENCY   = 2,
    parameter int ADDR_W         = 19
) (
    input  logic              clock,
    input  logic              reset,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       q,
`ifdef VGA_TEST_PATTERN_EN
    input  logic              pattern_en,
`endif
    output logic              frame_start,
    output logic              HS,
    output logic              VS,
    output logic [3:0]        VGA_R,
    output logic [3:0]        VGA_G,
    output logic [3:0]        VGA_B
);

    localparam logic [15:0] H_TOTAL = 16'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT);
    localparam logic [15:0] V_TOTAL = 16'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT);
    localparam logic [15:0] H_SYNC_E = 16'(H_SYNC);
    localparam logic [15:0] H_ACT_B  = 16'(H_SYNC + H_BACK);
    localparam logic [15:0] H_ACT_E  = 16'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [15:0] V_SYNC_E = 16'(V_SYNC);
    localparam logic [15:0] V_ACT_B  = 16'(V_SYNC + V_BACK);
    localparam logic [15:0] V_ACT_E  = 16'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic HS_IDLE = (HS_ACTIVE_HIGH == 0);
    localparam logic VS_IDLE = (VS_ACTIVE_HIGH == 0);

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic frame;
`ifdef VGA_TEST_PATTERN_EN
        logic        sel;
        logic [11:0] pat;
`endif
    } stage_t;

    logic [15:0]       hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic              de_raw, frame_raw;
    logic              rd_en_q;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    stage_t            st1_d;
    stage_t            pipe_q [0:READ_LATENCY];
    stage_t            so;
    logic [11:0]       pix;
    logic              hs_q, vs_q, fs_q;
    logic [11:0]       rgb_q;
    logic              unused_q_hi;

    assign unused_q_hi = ^q[15:12];

    always_comb begin
        hcnt_d = hcnt_q + 16'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_TOTAL - 16'd1) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_TOTAL - 16'd1) ? '0 : vcnt_q + 16'd1;
        end
    end

    assign de_raw    = (hcnt_q >= H_ACT_B) && (hcnt_q < H_ACT_E) &&
                       (vcnt_q >= V_ACT_B) && (vcnt_q < V_ACT_E);
    assign frame_raw = (hcnt_q == '0) && (vcnt_q == '0);

    // Address advances after each fetched pixel, so it already points at the next one.
    always_comb begin
        rd_addr_d = rd_addr_q;
        if (frame_raw)
            rd_addr_d = '0;
        else if (rd_en_q)
            rd_addr_d = rd_addr_q + ADDR_W'(1);
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [15:0] BAR_W = 16'(H_ACTIVE / 8);

    logic [15:0] px_q, px_d, px_cur;
    logic [2:0]  bar_q, bar_d, bar_cur;

    always_comb begin
        px_cur  = (hcnt_q == '0) ? '0 : px_q;
        bar_cur = (hcnt_q == '0) ? '0 : bar_q;
        px_d    = px_cur;
        bar_d   = bar_cur;
        if (de_raw) begin
            if (px_cur == BAR_W - 16'd1) begin
                px_d  = '0;
                bar_d = bar_cur + 3'd1;
            end else begin
                px_d = px_cur + 16'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            px_q  <= '0;
            bar_q <= '0;
        end else begin
            px_q  <= px_d;
            bar_q <= bar_d;
        end
    end
`endif

    always_comb begin
        st1_d       = '0;
        st1_d.hs    = hcnt_q < H_SYNC_E;
        st1_d.vs    = vcnt_q < V_SYNC_E;
        st1_d.de    = de_raw;
        st1_d.frame = frame_raw;
`ifdef VGA_TEST_PATTERN_EN
        st1_d.sel   = pattern_en;
        st1_d.pat   = {{4{bar_cur[2]}}, {4{bar_cur[1]}}, {4{bar_cur[0]}}};
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            for (int i = 0; i <= READ_LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            rd_en_q   <= de_raw;
            rd_addr_q <= rd_addr_d;
            pipe_q[0] <= st1_d;
            for (int i = 1; i <= READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign so = pipe_q[READ_LATENCY];

    always_comb begin
        pix = q[11:0];
`ifdef VGA_TEST_PATTERN_EN
        if (so.sel) pix = so.pat;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hs_q  <= HS_IDLE;
            vs_q  <= VS_IDLE;
            fs_q  <= 1'b0;
            rgb_q <= '0;
        end else begin
            hs_q  <= so.hs ^ HS_IDLE;
            vs_q  <= so.vs ^ VS_IDLE;
            fs_q  <= so.frame;
            rgb_q <= so.de ? pix : 12'h000;
        end
    end

    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;
    assign HS          = hs_q;
    assign VS          = vs_q;
    assign frame_start = fs_q;
    assign VGA_R       = rgb_q[11:8];
    assign VGA_G       = rgb_q[7:4];
    assign VGA_B       = rgb_q[3:0];

endmodule
